// File: rtl/leaf_bridge_pkg.sv
// Shared types and constants for the leaf/kernel stream bridge.
package leaf_bridge_pkg;

  typedef enum logic [0:0] {
    HOLD,
    RUN
  } bridge_state_e;

  // Wide enough for any practical kernel reset hold time.
  localparam int unsigned HOLD_CNT_W = 16;
  localparam int unsigned BEAT_CNT_W = 32;

  // Saturating increment for the beat counters.
  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Single-channel valid/ready FIFO with synchronous clear and an enable that
// forces both handshake sides idle. Ready and valid derive only from the
// registered occupancy, so there is no combinational path between the two sides.
module bridge_fifo #(
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PAYLOAD_BITS-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic                       pop;

  assign in_ready  = enable & (count != FULL_CNT);
  assign out_valid = enable & (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Pointer and occupancy tracking; clear discards everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Buffered bridge between leaf_interface user ports and an HLS kernel's
// AXI-stream ports. Sequences kernel ap_rst_n/ap_start and supports a
// synchronous flush that resets the kernel and empties every channel FIFO.
// Optional per-channel beat counters when BRIDGE_STATS_EN is defined.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned NUM_IN_PORTS    = 1,
  parameter int unsigned NUM_OUT_PORTS   = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned RST_HOLD_CYCLES = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  k_in_tdata,
  output logic [NUM_IN_PORTS-1:0]               k_in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]               k_in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] k_out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]              k_out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]              k_out_tready,
  output logic                                  ap_rst_n,
  output logic                                  ap_start,
  input  logic                                  ap_idle,
  output logic                                  running
`ifdef BRIDGE_STATS_EN
  ,
  output logic [NUM_IN_PORTS*BEAT_CNT_W-1:0]    in_beats,
  output logic [NUM_OUT_PORTS*BEAT_CNT_W-1:0]   out_beats
`endif
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD_CYCLES - 1);

  bridge_state_e          state;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic                   fifo_en;
  logic                   idle_sample_unused;

  // FIFOs only handshake while the kernel is out of reset.
  assign fifo_en = (state == RUN);

  // Kernel reset/start sequencing; flush behaves like a local reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= '0;
      ap_rst_n <= 1'b0;
      ap_start <= 1'b0;
      running  <= 1'b0;
    end else if (flush) begin
      state    <= HOLD;
      hold_cnt <= '0;
      ap_rst_n <= 1'b0;
      ap_start <= 1'b0;
      running  <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            hold_cnt <= '0;
            ap_rst_n <= 1'b1;
            ap_start <= 1'b1;
            running  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state    <= HOLD;
          hold_cnt <= '0;
          ap_rst_n <= 1'b0;
          ap_start <= 1'b0;
          running  <= 1'b0;
        end
      endcase
    end
  end

  // Kernel idle is captured for debug visibility only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_sample_unused <= 1'b0;
    else       idle_sample_unused <= ap_idle;
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    bridge_fifo #(
      .PAYLOAD_BITS    (PAYLOAD_BITS),
      .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .enable    (fifo_en),
      .in_data   (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_valid  (vld_interface2user[i]),
      .in_ready  (ack_user2interface[i]),
      .out_data  (k_in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_valid (k_in_tvalid[i]),
      .out_ready (k_in_tready[i])
    );
  end

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
    bridge_fifo #(
      .PAYLOAD_BITS    (PAYLOAD_BITS),
      .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .enable    (fifo_en),
      .in_data   (k_out_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_valid  (k_out_tvalid[i]),
      .in_ready  (k_out_tready[i]),
      .out_data  (din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_valid (vld_user2interface[i]),
      .out_ready (ack_interface2user[i])
    );
  end

`ifdef BRIDGE_STATS_EN
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_stats
    logic [BEAT_CNT_W-1:0] beats;
    // Count leaf-side transfers into the bridge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)      beats <= '0;
      else if (flush) beats <= '0;
      else if (vld_interface2user[i] && ack_user2interface[i]) beats <= sat_inc(beats);
    end
    assign in_beats[i*BEAT_CNT_W +: BEAT_CNT_W] = beats;
  end

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out_stats
    logic [BEAT_CNT_W-1:0] beats;
    // Count leaf-side transfers out of the bridge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)      beats <= '0;
      else if (flush) beats <= '0;
      else if (vld_user2interface[i] && ack_interface2user[i]) beats <= sat_inc(beats);
    end
    assign out_beats[i*BEAT_CNT_W +: BEAT_CNT_W] = beats;
  end
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed bench for leaf_stream_bridge with scoreboard queues per direction.
// Stats checks are compiled only when BRIDGE_STATS_EN is defined.
module tb_leaf_stream_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  // Single-channel instance
  logic [31:0] lin_d, lout_d, kin_d, kout_d;
  logic lin_v, lin_ack, lout_v, lout_ack, kin_v, kin_r, kout_v, kout_r;
  logic ap_rst_n, ap_start, ap_idle, running;

  // Multi-channel instance (2 in, 3 out)
  logic [63:0] b_lin_d, b_kin_d;
  logic [95:0] b_lout_d, b_kout_d;
  logic [1:0]  b_lin_v, b_lin_ack, b_kin_v, b_kin_r;
  logic [2:0]  b_lout_v, b_lout_ack, b_kout_v, b_kout_r;
  logic b_ap_rst_n, b_ap_start, b_running;

`ifdef BRIDGE_STATS_EN
  logic [31:0] in_beats, out_beats;
  logic [63:0] b_in_beats;
  logic [95:0] b_out_beats;
`endif

  leaf_stream_bridge u_dut (
    .clk                      (clk),
    .reset                    (rst),
    .flush                    (flush),
    .dout_leaf_interface2user (lin_d),
    .vld_interface2user       (lin_v),
    .ack_user2interface       (lin_ack),
    .din_leaf_user2interface  (lout_d),
    .vld_user2interface       (lout_v),
    .ack_interface2user       (lout_ack),
    .k_in_tdata               (kin_d),
    .k_in_tvalid              (kin_v),
    .k_in_tready              (kin_r),
    .k_out_tdata              (kout_d),
    .k_out_tvalid             (kout_v),
    .k_out_tready             (kout_r),
    .ap_rst_n                 (ap_rst_n),
    .ap_start                 (ap_start),
    .ap_idle                  (ap_idle),
    .running                  (running)
`ifdef BRIDGE_STATS_EN
    ,
    .in_beats                 (in_beats),
    .out_beats                (out_beats)
`endif
  );

  leaf_stream_bridge #(
    .NUM_IN_PORTS  (2),
    .NUM_OUT_PORTS (3)
  ) u_dut_multi (
    .clk                      (clk),
    .reset                    (rst),
    .flush                    (1'b0),
    .dout_leaf_interface2user (b_lin_d),
    .vld_interface2user       (b_lin_v),
    .ack_user2interface       (b_lin_ack),
    .din_leaf_user2interface  (b_lout_d),
    .vld_user2interface       (b_lout_v),
    .ack_interface2user       (b_lout_ack),
    .k_in_tdata               (b_kin_d),
    .k_in_tvalid              (b_kin_v),
    .k_in_tready              (b_kin_r),
    .k_out_tdata              (b_kout_d),
    .k_out_tvalid             (b_kout_v),
    .k_out_tready             (b_kout_r),
    .ap_rst_n                 (b_ap_rst_n),
    .ap_start                 (b_ap_start),
    .ap_idle                  (1'b1),
    .running                  (b_running)
`ifdef BRIDGE_STATS_EN
    ,
    .in_beats                 (b_in_beats),
    .out_beats                (b_out_beats)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_in[$], exp_out[$], src_in[$], src_out[$];
  int n_acc = 0, n_del = 0, n_oacc = 0, n_odel = 0;
  int b_acc_in[2];
  int b_acc_out[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes at the falling edge, then advance sources.
  task automatic tick();
    bit acc_in, acc_out;
    @(negedge clk);
    acc_in  = lin_v && lin_ack;
    acc_out = kout_v && kout_r;
    if (acc_in) begin
      exp_in.push_back(lin_d);
      n_acc++;
    end
    if (kin_v && kin_r) begin
      n_del++;
      chk("in_word_expected", 64'(exp_in.size() != 0), 64'd1);
      if (exp_in.size() != 0) chk("in_order", 64'(kin_d), 64'(exp_in.pop_front()));
    end
    if (acc_out) begin
      exp_out.push_back(kout_d);
      n_oacc++;
    end
    if (lout_v && lout_ack) begin
      n_odel++;
      chk("out_word_expected", 64'(exp_out.size() != 0), 64'd1);
      if (exp_out.size() != 0) chk("out_order", 64'(lout_d), 64'(exp_out.pop_front()));
    end
    for (int i = 0; i < 2; i++) if (b_lin_v[i] && b_lin_ack[i]) b_acc_in[i]++;
    for (int i = 0; i < 3; i++) if (b_kout_v[i] && b_kout_r[i]) b_acc_out[i]++;
    @(posedge clk);
    #1;
    if (acc_in || !lin_v) begin
      if (src_in.size() != 0) begin
        lin_d = src_in.pop_front();
        lin_v = 1'b1;
      end else lin_v = 1'b0;
    end
    if (acc_out || !kout_v) begin
      if (src_out.size() != 0) begin
        kout_d = src_out.pop_front();
        kout_v = 1'b1;
      end else kout_v = 1'b0;
    end
  endtask

  initial begin
    int base;
    bit hit;
    lin_d = '0; lin_v = 0; lout_ack = 0; kin_r = 0; kout_d = '0; kout_v = 0; ap_idle = 1;
    b_lin_d = '0; b_lin_v = '0; b_kin_r = '0; b_kout_d = '0; b_kout_v = '0; b_lout_ack = '0;
    for (int i = 0; i < 2; i++) b_acc_in[i] = 0;
    for (int i = 0; i < 3; i++) b_acc_out[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({lin_ack, kin_v, kout_r, lout_v, ap_rst_n, ap_start, running}), 64'd0);
    chk("rst_multi_ready", 64'({b_lin_ack, b_kout_r}), 64'd0);

    // Hold sequence: RUN reached on the 4th edge after release
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("hold_seq", 64'({ap_rst_n, ap_start, running}), (i == 4) ? 64'd7 : 64'd0);
    end
    chk("run_ready", 64'({lin_ack, kout_r}), 64'd3);

    // Backpressure: 5 words into depth 4 with the kernel stalled
    kin_r = 0;
    for (int w = 0; w < 5; w++) src_in.push_back(32'hA000_0000 + w);
    repeat (8) tick();
    chk("bp_accepted", 64'(n_acc), 64'd4);
    chk("bp_ack_low", 64'(lin_ack), 64'd0);
    chk("bp_tvalid", 64'(kin_v), 64'd1);
    kin_r = 1;
    tick();
    chk("bp_fifth_waits", 64'(n_acc), 64'd4);
    repeat (8) tick();
    chk("bp_all_accepted", 64'(n_acc), 64'd5);
    chk("bp_all_delivered", 64'(n_del), 64'd5);
    chk("bp_sb_empty", 64'(exp_in.size()), 64'd0);

    // Simultaneous push/pop at occupancy 2
    n_acc = 0; n_del = 0; kin_r = 0;
    for (int w = 0; w < 12; w++) src_in.push_back(32'hB000_0000 + w);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (n_acc == 2) hit = 1;
    end
    chk("pp_fill_reached", 64'(hit), 64'd1);
    kin_r = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pp_occupancy", 64'(n_acc - n_del), 64'd2);
    end
    repeat (6) tick();
    chk("pp_delivered", 64'(n_del), 64'd12);
    chk("pp_sb_empty", 64'(exp_in.size()), 64'd0);

    // Kernel-to-leaf direction with leaf backpressure
    lout_ack = 0;
    for (int w = 0; w < 6; w++) src_out.push_back(32'hC000_0000 + w);
    repeat (8) tick();
    chk("out_accepted", 64'(n_oacc), 64'd4);
    chk("out_tready_full", 64'(kout_r), 64'd0);
    chk("out_vld", 64'(lout_v), 64'd1);
    lout_ack = 1;
    repeat (10) tick();
    chk("out_delivered", 64'(n_odel), 64'd6);
    chk("out_sb_empty", 64'(exp_out.size()), 64'd0);

    // Flush with 3 words buffered
    n_acc = 0; kin_r = 0;
    for (int w = 0; w < 3; w++) src_in.push_back(32'hD000_0000 + w);
    repeat (6) tick();
    chk("fl_buffered", 64'(n_acc), 64'd3);
    flush = 1;
    tick();
    flush = 0;
    exp_in.delete();
    chk("fl_outputs", 64'({kin_v, lin_ack, lout_v, ap_rst_n, running}), 64'd0);
    kin_r = 1;
    base = n_del;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fl_hold_seq", 64'({ap_rst_n, running}), (i == 4) ? 64'd3 : 64'd0);
    end
    repeat (4) tick();
    chk("fl_no_old_valid", 64'(kin_v), 64'd0);
    chk("fl_nothing_delivered", 64'(n_del - base), 64'd0);

    // Independent per-channel backpressure on the multi-channel instance
    b_lin_d = {32'h2222_0001, 32'h1111_0001};
    b_kout_d = {32'h5555_0003, 32'h4444_0002, 32'h3333_0001};
    b_kin_r = 2'b01; b_lout_ack = 3'b011;
    b_lin_v = 2'b11; b_kout_v = 3'b111;
    repeat (8) tick();
    chk("mc_in0_acc", 64'(b_acc_in[0]), 64'd8);
    chk("mc_in1_acc", 64'(b_acc_in[1]), 64'd4);
    chk("mc_in_ack", 64'(b_lin_ack), 64'd1);
    chk("mc_in_tvalid", 64'(b_kin_v), 64'd3);
    chk("mc_in0_data", 64'(b_kin_d[31:0]), 64'h1111_0001);
    chk("mc_out0_acc", 64'(b_acc_out[0]), 64'd8);
    chk("mc_out1_acc", 64'(b_acc_out[1]), 64'd8);
    chk("mc_out2_acc", 64'(b_acc_out[2]), 64'd4);
    chk("mc_out_tready", 64'(b_kout_r), 64'd3);
    chk("mc_out1_data", 64'(b_lout_d[63:32]), 64'h4444_0002);
    b_lin_v = '0; b_kout_v = '0;

`ifdef BRIDGE_STATS_EN
    // Beat counters: 7 leaf-side transfers, cleared by flush
    n_acc = 0; kin_r = 1;
    for (int w = 0; w < 7; w++) src_in.push_back(32'hE000_0000 + w);
    repeat (14) tick();
    chk("st_transfers", 64'(n_acc), 64'd7);
    chk("st_in_beats", 64'(in_beats), 64'd7);
    chk("st_out_beats", 64'(out_beats), 64'd0);
    flush = 1;
    tick();
    flush = 0;
    exp_in.delete();
    chk("st_in_beats_flush", 64'(in_beats), 64'd0);
    repeat (4) tick();
`endif

    // Asynchronous reset mid-transfer drops outputs with no clock edge
    kin_r = 0;
    for (int w = 0; w < 2; w++) src_in.push_back(32'hF000_0000 + w);
    repeat (4) tick();
    chk("ar_buffered", 64'(kin_v), 64'd1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("ar_outputs", 64'({lin_ack, kin_v, kout_r, lout_v, ap_rst_n, ap_start, running}), 64'd0);
    chk("ar_multi", 64'({b_lin_ack, b_kout_r, b_running}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
